router_sync: RTL and testbench
==============================

// Module: router_sync
// PURPOSE
//  Synchronizer/steering stage directly upstream of the three router_fifo instances in the 1x3 router.
//  - Latches the 2-bit destination address of each packet header.
//  - Steers the FSM write strobe to exactly one FIFO and returns that FIFO's full flag to the FSM.
//  - Drives vld_out per output port.
//  - Runs per-port read-timeout counters that raise soft_reset to flush a FIFO its receiver abandons.
// PARAMETERS
//  TIMEOUT  30  consecutive unread-valid cycles before soft_reset pulses (2..2**CNT_W)
//  CNT_W    5   timeout counter width
// PORTS
//  clock          in   1  system clock, all state on rising edge
//  resetn         in   1  synchronous, active-low reset
//  detect_add     in   1  FSM header-detect strobe; capture data_in as destination
//  data_in        in   2  destination address bits [1:0] of header byte
//  write_enb_reg  in   1  FSM write request for current packet byte
//  read_enb_0/1/2 in   1  receiver read enable, port 0/1/2
//  empty_0/1/2    in   1  FIFO empty flag, port 0/1/2
//  full_0/1/2     in   1  FIFO full flag, port 0/1/2
//  write_enb      out  3  one-hot FIFO write enables, bit n -> FIFO n
//  fifo_full      out  1  full flag of the currently addressed FIFO
//  vld_out_0/1/2  out  1  data valid to receiver n (= ~empty_n)
//  soft_reset_0/1/2 out 1 one-cycle flush pulse to FIFO n
// BEHAVIOUR
//  Address register addr[1:0]
//  - Reset value 2'b00.
//  - Loads data_in on any clock edge with detect_add=1; otherwise holds.
//  - Loaded value is visible from the following cycle.
//  Write steering (combinational from addr)
//  - write_enb = write_enb_reg ? onehot(addr) : 3'b000.
//  - addr=2'b11 (invalid port) -> write_enb=3'b000 regardless of write_enb_reg.
//  - detect_add and write_enb_reg high in the same cycle -> steering uses the old addr.
//  - Never more than one write_enb bit set.
//  fifo_full (combinational)
//  - Equals full_<addr> for addr 0..2; 0 for addr=3.
//  - Depends on addr only, not on write_enb_reg.
//  vld_out_n = ~empty_n (combinational; during reset follows empty_n).
//  Timeout counter, per port n: cnt_n[CNT_W-1:0] and registered soft_reset_n; both reset to 0. Each edge:
//  - vld_out_n=0 or read_enb_n=1 -> cnt_n<=0, soft_reset_n<=0.
//  - else if cnt_n==TIMEOUT-1 -> cnt_n<=0, soft_reset_n<=1.
//  - else -> cnt_n<=cnt_n+1, soft_reset_n<=0.
//  Timeout timing
//  - soft_reset_n goes high after exactly TIMEOUT consecutive edges sampling vld&~read.
//  - It lasts exactly one cycle.
//  - If the condition persists, the next pulse comes TIMEOUT cycles later.
//  - Any single-cycle read or empty restarts the count from 0.
//  The three counters are independent; simultaneous pulses on several ports are legal.
//  Reset has priority over all other inputs.
//  - Reset mid-count clears cnt_n and soft_reset_n and returns addr to 0 on that edge.
//  - No pulse is generated in the cycle after reset release.
// TESTING
//  - Reset: resetn=0 for 2 edges -> write_enb=000, soft_reset_*=0, addr=0; with empty_*=1, vld_out_*=0.
//  - Steering: detect_add=1,data_in=2'b10, then write_enb_reg=1 -> write_enb=3'b100; full_2=1 -> fifo_full=1, full_0=1 alone -> 0.
//  - Invalid address: data_in=2'b11 latched, write_enb_reg=1 -> write_enb=000, fifo_full=0 with all full_*=1.
//  - Timeout: empty_1=0, read_enb_1=0 held -> soft_reset_1 high only in the cycle after the 30th edge, low next; second pulse 30 cycles later.
//  - Counter restart: empty_0=0, read_enb_0 pulsed at edge 29 -> no pulse at 30; pulse 30 edges after read_enb_0 drops.
//  - Reset mid-count: resetn=0 at edge 20 of a port-2 timeout -> no pulse; count restarts, pulse 30 edges after release.

Source files
------------

// File: rtl/router_sync_if.sv
// =============================================================================
//  router_sync_if : FSM/FIFO-side signal bundle for the router_sync stage
//  Revision 1.0
// =============================================================================
`default_nettype none

interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0;
  logic       read_enb_1;
  logic       read_enb_2;
  logic       empty_0;
  logic       empty_1;
  logic       empty_2;
  logic       full_0;
  logic       full_1;
  logic       full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0;
  logic       vld_out_1;
  logic       vld_out_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

`default_nettype wire

// File: rtl/router_sync.sv
// =============================================================================
//  router_sync : destination latch, write steering and per-port read timeouts
//  Revision 1.0
// =============================================================================
`default_nettype none

module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  wire logic    clock,
  input  wire logic    resetn,
  router_sync_if.slave bus
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(TIMEOUT - 1);

  logic [1:0] addr_q, addr_d;
  logic [2:0] vld, rd, soft_reset_q;

  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) addr_d = bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) addr_q <= 2'b00;
    else         addr_q <= addr_d;
  end

  // Address 3 is not a port: no write strobe and no full flag.
  always_comb begin
    bus.write_enb = 3'b000;
    bus.fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        bus.write_enb = {2'b00, bus.write_enb_reg};
        bus.fifo_full = bus.full_0;
      end
      2'b01: begin
        bus.write_enb = {1'b0, bus.write_enb_reg, 1'b0};
        bus.fifo_full = bus.full_1;
      end
      2'b10: begin
        bus.write_enb = {bus.write_enb_reg, 2'b00};
        bus.fifo_full = bus.full_2;
      end
      default: begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
      end
    endcase
  end

  assign vld = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign rd  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

  assign bus.vld_out_0 = vld[0];
  assign bus.vld_out_1 = vld[1];
  assign bus.vld_out_2 = vld[2];

  generate
    for (genvar n = 0; n < 3; n++) begin : g_port
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             soft_reset_d;

      always_comb begin
        cnt_d        = cnt_q + 1'b1;
        soft_reset_d = 1'b0;
        if (!vld[n] || rd[n]) begin
          cnt_d = '0;
        end else if (cnt_q == c_last_cnt) begin
          cnt_d        = '0;
          soft_reset_d = 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt_q           <= '0;
          soft_reset_q[n] <= 1'b0;
        end else begin
          cnt_q           <= cnt_d;
          soft_reset_q[n] <= soft_reset_d;
        end
      end
    end
  endgenerate

  assign bus.soft_reset_0 = soft_reset_q[0];
  assign bus.soft_reset_1 = soft_reset_q[1];
  assign bus.soft_reset_2 = soft_reset_q[2];

endmodule

`default_nettype wire

// File: tb/tb_router_sync.sv
// =============================================================================
//  tb_router_sync : directed self-checking bench for router_sync
//  Revision 1.0
// =============================================================================
`default_nettype none

module tb_router_sync;
  logic clock;
  logic resetn;
  int   n_checks;
  int   n_fail;

  router_sync_if bus ();

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and step just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
    bus.empty_0    = 1'b1; bus.empty_1    = 1'b1; bus.empty_2    = 1'b1;
    bus.full_0     = 1'b0; bus.full_1     = 1'b0; bus.full_2     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn         = 1'b0;
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b10;
    tick();
    tick();
    n_checks++;
    if (bus.write_enb !== 3'b000) begin
      n_fail++; $display("FAIL reset_write_enb got %b want 000", bus.write_enb);
    end
    n_checks++;
    if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_soft_reset got %b want 000",
                         {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    end
    n_checks++;
    if ({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_vld_out got %b want 000",
                         {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0});
    end
    // addr must be 0 despite detect_add during reset
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0        = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b001) begin
      n_fail++; $display("FAIL reset_addr_steer got %b want 001", bus.write_enb);
    end
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL reset_addr_full got %b want 1", bus.fifo_full);
    end
    bus.empty_1 = 1'b0;
    #1;
    n_checks++;
    if (bus.vld_out_1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_vld_follow got %b want 1", bus.vld_out_1);
    end
    idle_inputs();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_steering();
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b10;
    tick();
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b100) begin
      n_fail++; $display("FAIL steer_port2 got %b want 100", bus.write_enb);
    end
    bus.full_2 = 1'b1;
    #1;
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL steer_full2 got %b want 1", bus.fifo_full);
    end
    bus.full_2 = 1'b0;
    bus.full_0 = 1'b1;
    #1;
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL steer_full0_only got %b want 0", bus.fifo_full);
    end
    bus.full_0        = 1'b0;
    bus.full_2        = 1'b1;
    bus.write_enb_reg = 1'b0;
    #1;
    n_checks++;
    if ({bus.write_enb, bus.fifo_full} !== 4'b000_1) begin
      n_fail++; $display("FAIL steer_no_req got %b/%b want 000/1", bus.write_enb, bus.fifo_full);
    end
    // Same-cycle detect_add: steering still uses the old address
    bus.full_2        = 1'b0;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'b01;
    bus.write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b100) begin
      n_fail++; $display("FAIL steer_old_addr got %b want 100", bus.write_enb);
    end
    tick();
    bus.detect_add = 1'b0;
    bus.full_1     = 1'b1;
    #1;
    n_checks++;
    if ({bus.write_enb, bus.fifo_full} !== 4'b010_1) begin
      n_fail++; $display("FAIL steer_port1 got %b/%b want 010/1", bus.write_enb, bus.fifo_full);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_invalid_addr();
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b11;
    tick();
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b1; bus.full_1 = 1'b1; bus.full_2 = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b000) begin
      n_fail++; $display("FAIL invalid_write_enb got %b want 000", bus.write_enb);
    end
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL invalid_fifo_full got %b want 0", bus.fifo_full);
    end
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    tick();
    bus.detect_add = 1'b0;
    #1;
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL invalid_to_port0_full got %b want 1", bus.fifo_full);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bus.empty_1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      n_checks++;
      if (bus.soft_reset_1 !== (k == 30 || k == 60)) begin
        n_fail++; $display("FAIL timeout_p1 edge %0d got %b want %b", k, bus.soft_reset_1, (k == 30 || k == 60));
      end
      if (k == 31) begin
        n_checks++;
        if ({bus.soft_reset_2, bus.soft_reset_0} !== 2'b00) begin
          n_fail++; $display("FAIL timeout_others got %b want 00", {bus.soft_reset_2, bus.soft_reset_0});
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_counter_restart();
    bus.empty_0 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      bus.read_enb_0 = (k == 29);
      tick();
      n_checks++;
      if (bus.soft_reset_0 !== (k == 59)) begin
        n_fail++; $display("FAIL restart_p0 edge %0d got %b want %b", k, bus.soft_reset_0, (k == 59));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_count();
    bus.empty_2 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      resetn = (k != 20);
      tick();
      n_checks++;
      if (bus.soft_reset_2 !== (k == 50)) begin
        n_fail++; $display("FAIL reset_mid_p2 edge %0d got %b want %b", k, bus.soft_reset_2, (k == 50));
      end
    end
    resetn = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    bus.empty_0 = 1'b0;
    bus.empty_2 = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      n_checks++;
      if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== ((k == 30) ? 3'b101 : 3'b000)) begin
        n_fail++; $display("FAIL simultaneous edge %0d got %b want %b", k,
                           {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0},
                           ((k == 30) ? 3'b101 : 3'b000));
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    idle_inputs();
    test_reset();
    test_steering();
    test_invalid_addr();
    test_timeout();
    test_counter_restart();
    test_reset_mid_count();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
